// File: rtl/nios_system_video_pkg.sv
// rtl/nios_system_video_pkg.sv - shared state enum and default sizing for the 2x video scaler
package nios_system_video_pkg;

   typedef enum logic [1:0] {
      PASS   = 2'd0,
      PRIME  = 2'd1,
      REPLAY = 2'd2
   } scaler_state_e;

   localparam int DEFAULT_DW       = 29;
   localparam int DEFAULT_EW       = 1;
   localparam int DEFAULT_WIDTH_IN = 320;
   localparam int DEFAULT_AW       = 9;

endpackage

// File: rtl/nios_system_video_scaler_line_buffer.sv
// rtl/nios_system_video_scaler_line_buffer.sv - one-line pixel store, sync write, registered read
module nios_system_video_scaler_line_buffer
   import nios_system_video_pkg::*;
#(
   parameter int DW       = DEFAULT_DW,
   parameter int WIDTH_IN = DEFAULT_WIDTH_IN,
   parameter int AW       = DEFAULT_AW
)(
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW:0]   wr_addr,
   input  logic [DW:0]   wr_data,
   input  logic [AW:0]   rd_addr,
   output logic [DW:0]   rd_data
);

   logic [DW:0] mem [WIDTH_IN];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/nios_system_video_scaler.sv
// rtl/nios_system_video_scaler.sv - 2x horizontal and vertical upscaler for a 10:10:10 RGB stream
module nios_system_video_scaler
   import nios_system_video_pkg::*;
#(
   parameter int DW       = DEFAULT_DW,
   parameter int EW       = DEFAULT_EW,
   parameter int WIDTH_IN = DEFAULT_WIDTH_IN,
   parameter int AW       = DEFAULT_AW
)(
   input  logic          clk,
   input  logic          reset,
   input  logic [DW:0]   stream_in_data,
   input  logic          stream_in_startofpacket,
   input  logic          stream_in_endofpacket,
   input  logic [EW:0]   stream_in_empty,
   input  logic          stream_in_valid,
   output logic          stream_in_ready,
   input  logic          stream_out_ready,
   output logic [DW:0]   stream_out_data,
   output logic          stream_out_startofpacket,
   output logic          stream_out_endofpacket,
   output logic [EW:0]   stream_out_empty,
   output logic          stream_out_valid
);

   localparam logic [AW:0] LAST_COL = (AW+1)'(WIDTH_IN - 1);

   scaler_state_e state;
   logic [AW:0]   col;
   logic [AW:0]   col_inc;
   logic [AW:0]   wr_addr;
   logic [AW:0]   rd_addr;
   logic [AW+1:0] len;
   logic [AW+1:0] col_len;
   logic          dup;
   logic          slot_free;
   logic          accept;
   logic          last_copy;
   logic [DW:0]   hold_data;
   logic [DW:0]   rd_data;
   logic [EW:0]   hold_empty;
   logic [EW:0]   line_empty;
   logic          hold_eop;
   logic          line_eop;

   assign slot_free       = stream_out_ready | ~stream_out_valid;
   assign stream_in_ready = reset & (state == PASS) & ~dup & slot_free;
   assign accept          = stream_in_ready & stream_in_valid;
   assign col_inc         = col + (AW+1)'(1);
   assign col_len         = (AW+2)'(col) + (AW+2)'(1);
   // A start-of-frame pixel always lands at column 0, abandoning any partial line.
   assign wr_addr         = stream_in_startofpacket ? '0 : col;
   // Prefetch the next column on the second copy so REPLAY streams without bubbles.
   assign rd_addr         = (state == REPLAY && slot_free && dup) ? col_inc : col;
   assign last_copy       = dup & (col_len == len);

   nios_system_video_scaler_line_buffer #(
      .DW       (DW),
      .WIDTH_IN (WIDTH_IN),
      .AW       (AW)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (wr_addr),
      .wr_data (stream_in_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // In REPLAY, dup doubles as the copy index of the buffered pixel being emitted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                    <= PASS;
         col                      <= '0;
         dup                      <= 1'b0;
         len                      <= '0;
         hold_data                <= '0;
         hold_empty               <= '0;
         hold_eop                 <= 1'b0;
         line_empty               <= '0;
         line_eop                 <= 1'b0;
         stream_out_data          <= '0;
         stream_out_startofpacket <= 1'b0;
         stream_out_endofpacket   <= 1'b0;
         stream_out_empty         <= '0;
         stream_out_valid         <= 1'b0;
      end else begin
         case (state)
            PASS: begin
               if (slot_free) begin
                  if (dup) begin
                     stream_out_data          <= hold_data;
                     stream_out_startofpacket <= 1'b0;
                     stream_out_endofpacket   <= 1'b0;
                     stream_out_empty         <= hold_empty;
                     stream_out_valid         <= 1'b1;
                     dup                      <= 1'b0;
                     if (col == LAST_COL || hold_eop) begin
                        len        <= col_len;
                        col        <= '0;
                        line_eop   <= hold_eop;
                        line_empty <= hold_empty;
                        state      <= PRIME;
                     end else begin
                        col <= col_inc;
                     end
                  end else if (stream_in_valid) begin
                     stream_out_data          <= stream_in_data;
                     stream_out_startofpacket <= stream_in_startofpacket;
                     stream_out_endofpacket   <= 1'b0;
                     stream_out_empty         <= stream_in_empty;
                     stream_out_valid         <= 1'b1;
                     hold_data                <= stream_in_data;
                     hold_empty               <= stream_in_empty;
                     hold_eop                 <= stream_in_endofpacket;
                     col                      <= wr_addr;
                     dup                      <= 1'b1;
                  end else begin
                     stream_out_valid <= 1'b0;
                  end
               end
            end
            PRIME: begin
               if (slot_free) begin
                  stream_out_valid <= 1'b0;
               end
               state <= REPLAY;
            end
            REPLAY: begin
               if (slot_free) begin
                  stream_out_data          <= rd_data;
                  stream_out_startofpacket <= 1'b0;
                  stream_out_endofpacket   <= last_copy & line_eop;
                  stream_out_empty         <= (last_copy & line_eop) ? line_empty : '0;
                  stream_out_valid         <= 1'b1;
                  if (dup) begin
                     dup <= 1'b0;
                     if (last_copy) begin
                        col   <= '0;
                        state <= PASS;
                     end else begin
                        col <= col_inc;
                     end
                  end else begin
                     dup <= 1'b1;
                  end
               end
            end
            default: state <= PASS;
         endcase
      end
   end

endmodule

// File: tb/tb_nios_system_video_scaler.sv
// tb/tb_nios_system_video_scaler.sv - directed self-checking bench for the 2x video scaler
module tb_nios_system_video_scaler;

   localparam int DW = 29;
   localparam int EW = 1;
   localparam int WIDTH_IN = 4;
   localparam int AW = 1;

   typedef struct packed {
      logic [DW:0] data;
      logic        sop;
      logic        eop;
      logic [EW:0] empty;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW:0]   stream_in_data = '0;
   logic          stream_in_startofpacket = 1'b0;
   logic          stream_in_endofpacket = 1'b0;
   logic [EW:0]   stream_in_empty = '0;
   logic          stream_in_valid = 1'b0;
   logic          stream_in_ready;
   logic          stream_out_ready = 1'b1;
   logic [DW:0]   stream_out_data;
   logic          stream_out_startofpacket;
   logic          stream_out_endofpacket;
   logic [EW:0]   stream_out_empty;
   logic          stream_out_valid;

   int tests_run = 0;
   int tests_failed = 0;
   int stall_err = 0;

   beat_t in_q[$];
   beat_t exp_q[$];
   beat_t act_q[$];

   nios_system_video_scaler #(
      .DW       (DW),
      .EW       (EW),
      .WIDTH_IN (WIDTH_IN),
      .AW       (AW)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .stream_in_data           (stream_in_data),
      .stream_in_startofpacket  (stream_in_startofpacket),
      .stream_in_endofpacket    (stream_in_endofpacket),
      .stream_in_empty          (stream_in_empty),
      .stream_in_valid          (stream_in_valid),
      .stream_in_ready          (stream_in_ready),
      .stream_out_ready         (stream_out_ready),
      .stream_out_data          (stream_out_data),
      .stream_out_startofpacket (stream_out_startofpacket),
      .stream_out_endofpacket   (stream_out_endofpacket),
      .stream_out_empty         (stream_out_empty),
      .stream_out_valid         (stream_out_valid)
   );

   always #5 clk = ~clk;

   task automatic push_in(input logic [DW:0] d, input logic s, input logic e, input logic [EW:0] em);
      beat_t b;
      b.data = d; b.sop = s; b.eop = e; b.empty = em;
      in_q.push_back(b);
   endtask

   task automatic push_exp(input logic [DW:0] d, input logic s, input logic e, input logic [EW:0] em);
      beat_t b;
      b.data = d; b.sop = s; b.eop = e; b.empty = em;
      exp_q.push_back(b);
   endtask

   task automatic drive(input int idx);
      if (idx < in_q.size()) begin
         stream_in_valid         = 1'b1;
         stream_in_data          = in_q[idx].data;
         stream_in_startofpacket = in_q[idx].sop;
         stream_in_endofpacket   = in_q[idx].eop;
         stream_in_empty         = in_q[idx].empty;
      end else begin
         stream_in_valid         = 1'b0;
         stream_in_data          = '0;
         stream_in_startofpacket = 1'b0;
         stream_in_endofpacket   = 1'b0;
         stream_in_empty         = '0;
      end
   endtask

   // Feeds in_q and gathers accepted output beats into act_q; leaves comparisons to the caller.
   task automatic run(input bit rnd, input int max_beats, input int budget);
      int idx = 0;
      bit in_fire;
      bit prev_stall = 1'b0;
      logic [DW:0] prev_data = '0;
      beat_t b;
      act_q.delete();
      stall_err = 0;
      drive(idx);
      stream_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         if (prev_stall && (!stream_out_valid || stream_out_data !== prev_data)) stall_err++;
         prev_stall = stream_out_valid && !stream_out_ready;
         prev_data  = stream_out_data;
         if (stream_out_valid && stream_out_ready) begin
            b.data = stream_out_data; b.sop = stream_out_startofpacket;
            b.eop = stream_out_endofpacket; b.empty = stream_out_empty;
            act_q.push_back(b);
         end
         in_fire = stream_in_valid && stream_in_ready;
         @(posedge clk); #1;
         if (in_fire) idx++;
         drive(idx);
         stream_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (act_q.size() >= max_beats) break;
      end
      stream_in_valid  = 1'b0;
      stream_out_ready = 1'b1;
   endtask

   task automatic build_two_lines();
      logic [EW:0] em_in [8];
      in_q.delete(); exp_q.delete();
      for (int p = 0; p < 8; p++) em_in[p] = (p == 4) ? 2'd1 : (p == 7) ? 2'd2 : 2'd0;
      for (int p = 0; p < 8; p++) push_in(30'h100 + 30'(p), p == 0, p == 7, em_in[p]);
      for (int l = 0; l < 2; l++)
         for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
               for (int c = 0; c < 2; c++) begin
                  bit s, e;
                  s = (l == 0 && r == 0 && i == 0 && c == 0);
                  e = (l == 1 && r == 1 && i == 3 && c == 1);
                  push_exp(30'h100 + 30'(l * 4 + i), s, e, (r == 0 || e) ? em_in[l * 4 + i] : 2'd0);
               end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      stream_in_valid = 1'b1;
      #1;
      tests_run++;
      if ({stream_out_valid, stream_out_data, stream_out_startofpacket, stream_out_endofpacket, stream_out_empty} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got valid=%b data=%h sop=%b eop=%b empty=%h required all 0",
                  stream_out_valid, stream_out_data, stream_out_startofpacket, stream_out_endofpacket, stream_out_empty);
      end
      tests_run++;
      if (stream_in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_in_ready: got %b required 0", stream_in_ready);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      tests_run++;
      if (stream_in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL release_in_ready: got %b required 1", stream_in_ready);
      end
      stream_in_valid = 1'b0;
   endtask

   task automatic test_two_lines();
      build_two_lines();
      run(1'b0, 32, 200);
      tests_run++;
      if (act_q.size() !== 32) begin
         tests_failed++;
         $display("FAIL two_lines_count: got %0d beats required 32", act_q.size());
      end
      for (int i = 0; i < 32 && i < act_q.size(); i++) begin
         tests_run++;
         if (act_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL two_lines beat %0d: got %h required %h", i, act_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random_ready();
      build_two_lines();
      run(1'b1, 32, 600);
      tests_run++;
      if (act_q.size() !== 32) begin
         tests_failed++;
         $display("FAIL random_ready_count: got %0d beats required 32", act_q.size());
      end
      for (int i = 0; i < 32 && i < act_q.size(); i++) begin
         tests_run++;
         if (act_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL random_ready beat %0d: got %h required %h", i, act_q[i], exp_q[i]);
         end
      end
      tests_run++;
      if (stall_err !== 0) begin
         tests_failed++;
         $display("FAIL random_ready_stable: got %0d unstable stalled beats required 0", stall_err);
      end
   endtask

   task automatic test_short_line();
      in_q.delete(); exp_q.delete();
      push_in(30'h0AA, 1'b1, 1'b0, 2'd0);
      push_in(30'h0BB, 1'b0, 1'b1, 2'd0);
      push_exp(30'h0AA, 1'b1, 1'b0, 2'd0);
      push_exp(30'h0AA, 1'b0, 1'b0, 2'd0);
      push_exp(30'h0BB, 1'b0, 1'b0, 2'd0);
      push_exp(30'h0BB, 1'b0, 1'b0, 2'd0);
      push_exp(30'h0AA, 1'b0, 1'b0, 2'd0);
      push_exp(30'h0AA, 1'b0, 1'b0, 2'd0);
      push_exp(30'h0BB, 1'b0, 1'b0, 2'd0);
      push_exp(30'h0BB, 1'b0, 1'b1, 2'd0);
      run(1'b0, 8, 100);
      tests_run++;
      if (act_q.size() !== 8) begin
         tests_failed++;
         $display("FAIL short_line_count: got %0d beats required 8", act_q.size());
      end
      for (int i = 0; i < 8 && i < act_q.size(); i++) begin
         tests_run++;
         if (act_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL short_line beat %0d: got %h required %h", i, act_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_single_pixel();
      in_q.delete(); exp_q.delete();
      push_in(30'h3FF_0001, 1'b1, 1'b1, 2'd3);
      push_exp(30'h3FF_0001, 1'b1, 1'b0, 2'd3);
      push_exp(30'h3FF_0001, 1'b0, 1'b0, 2'd3);
      push_exp(30'h3FF_0001, 1'b0, 1'b0, 2'd0);
      push_exp(30'h3FF_0001, 1'b0, 1'b1, 2'd3);
      run(1'b0, 4, 60);
      tests_run++;
      if (act_q.size() !== 4) begin
         tests_failed++;
         $display("FAIL single_pixel_count: got %0d beats required 4", act_q.size());
      end
      for (int i = 0; i < 4 && i < act_q.size(); i++) begin
         tests_run++;
         if (act_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL single_pixel beat %0d: got %h required %h", i, act_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_resync();
      in_q.delete(); exp_q.delete();
      push_in(30'h010, 1'b1, 1'b0, 2'd0);
      push_in(30'h011, 1'b0, 1'b0, 2'd0);
      push_in(30'h020, 1'b1, 1'b0, 2'd0);
      push_in(30'h021, 1'b0, 1'b1, 2'd1);
      push_exp(30'h010, 1'b1, 1'b0, 2'd0);
      push_exp(30'h010, 1'b0, 1'b0, 2'd0);
      push_exp(30'h011, 1'b0, 1'b0, 2'd0);
      push_exp(30'h011, 1'b0, 1'b0, 2'd0);
      push_exp(30'h020, 1'b1, 1'b0, 2'd0);
      push_exp(30'h020, 1'b0, 1'b0, 2'd0);
      push_exp(30'h021, 1'b0, 1'b0, 2'd1);
      push_exp(30'h021, 1'b0, 1'b0, 2'd1);
      push_exp(30'h020, 1'b0, 1'b0, 2'd0);
      push_exp(30'h020, 1'b0, 1'b0, 2'd0);
      push_exp(30'h021, 1'b0, 1'b0, 2'd0);
      push_exp(30'h021, 1'b0, 1'b1, 2'd1);
      run(1'b0, 12, 120);
      tests_run++;
      if (act_q.size() !== 12) begin
         tests_failed++;
         $display("FAIL resync_count: got %0d beats required 12", act_q.size());
      end
      for (int i = 0; i < 12 && i < act_q.size(); i++) begin
         tests_run++;
         if (act_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL resync beat %0d: got %h required %h", i, act_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_replay();
      in_q.delete(); exp_q.delete();
      for (int p = 0; p < 4; p++) push_in(30'h200 + 30'(p), p == 0, p == 3, 2'd0);
      run(1'b0, 10, 100);
      stream_in_valid = 1'b1;
      reset = 1'b0;
      #1;
      tests_run++;
      if ({stream_out_valid, stream_out_data, stream_out_startofpacket, stream_out_endofpacket, stream_out_empty} !== '0) begin
         tests_failed++;
         $display("FAIL mid_replay_reset_outputs: got valid=%b data=%h sop=%b eop=%b empty=%h required all 0",
                  stream_out_valid, stream_out_data, stream_out_startofpacket, stream_out_endofpacket, stream_out_empty);
      end
      tests_run++;
      if (stream_in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_replay_reset_in_ready: got %b required 0", stream_in_ready);
      end
      stream_in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      in_q.delete(); exp_q.delete();
      push_in(30'h055, 1'b1, 1'b0, 2'd0);
      push_in(30'h066, 1'b0, 1'b1, 2'd2);
      push_exp(30'h055, 1'b1, 1'b0, 2'd0);
      push_exp(30'h055, 1'b0, 1'b0, 2'd0);
      push_exp(30'h066, 1'b0, 1'b0, 2'd2);
      push_exp(30'h066, 1'b0, 1'b0, 2'd2);
      push_exp(30'h055, 1'b0, 1'b0, 2'd0);
      push_exp(30'h055, 1'b0, 1'b0, 2'd0);
      push_exp(30'h066, 1'b0, 1'b0, 2'd0);
      push_exp(30'h066, 1'b0, 1'b1, 2'd2);
      run(1'b0, 8, 100);
      tests_run++;
      if (act_q.size() !== 8) begin
         tests_failed++;
         $display("FAIL after_reset_count: got %0d beats required 8", act_q.size());
      end
      for (int i = 0; i < 8 && i < act_q.size(); i++) begin
         tests_run++;
         if (act_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL after_reset beat %0d: got %h required %h", i, act_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_two_lines();
      test_random_ready();
      test_short_line();
      test_single_pixel();
      test_resync();
      test_reset_mid_replay();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
